// File: rtl/noc2_out_arb.sv
// Two-requester, packet-atomic arbiter sharing one NoC2 output channel.
// Define NOC2_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module noc2_out_arb #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_MSB    = 29,
  parameter int LEN_LSB    = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  noc2_valid_out,
  output logic [DATA_WIDTH-1:0] noc2_data_out,
  input  logic                  noc2_ready_out,
  output logic                  busy,
  output logic [1:0]            grant
);

  // state | meaning
  // IDLE  | no packet in flight; arbitrate among valid requesters
  // SEND  | header accepted; locked owner streams the remaining flits
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  localparam int LW = LEN_MSB - LEN_LSB + 1;

  state_e          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic            sel0, sel1;
  logic            xfer;
  logic [LW-1:0]   hdr_len;
`ifdef NOC2_ARB_RR_EN
  logic            last_q, last_d;
`endif

  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (state_q == SEND) begin
      sel0 = ~owner_q;
      sel1 = owner_q;
    end else begin
`ifdef NOC2_ARB_RR_EN
      // last_q names the previous winner; on contention the other one goes
      if (req0_valid && req1_valid) begin
        sel0 = last_q;
        sel1 = ~last_q;
      end else begin
        sel0 = req0_valid;
        sel1 = req1_valid;
      end
`else
      sel0 = req0_valid;
      sel1 = ~req0_valid & req1_valid;
`endif
    end
  end

  always_comb begin
    noc2_valid_out = 1'b0;
    noc2_data_out  = '0;
    if (sel0) begin
      noc2_valid_out = req0_valid;
      noc2_data_out  = req0_data;
    end else if (sel1) begin
      noc2_valid_out = req1_valid;
      noc2_data_out  = req1_data;
    end
  end

  assign req0_ready = sel0 & noc2_ready_out;
  assign req1_ready = sel1 & noc2_ready_out;
  assign grant      = {sel1, sel0};
  assign busy       = (state_q == SEND);
  assign xfer       = noc2_valid_out & noc2_ready_out;
  assign hdr_len    = noc2_data_out[LEN_MSB:LEN_LSB];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
`ifdef NOC2_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) begin
`ifdef NOC2_ARB_RR_EN
          last_d = sel1;
`endif
          if (hdr_len != '0) begin
            state_d = SEND;
            cnt_d   = hdr_len;
            owner_d = sel1;
          end
        end
      end
      SEND: begin
        if (xfer) begin
          cnt_d = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
`ifdef NOC2_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
`ifdef NOC2_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_noc2_out_arb.sv
// Directed bench for noc2_out_arb: arbitration, packet atomicity, back-pressure and reset.
module tb_noc2_out_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [63:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        noc2_valid_out;
  logic [63:0] noc2_data_out;
  logic        noc2_ready_out;
  logic        busy;
  logic [1:0]  grant;

  int npass = 0;
  int ntot  = 0;

  noc2_out_arb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid     (req0_valid),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .noc2_valid_out (noc2_valid_out),
    .noc2_data_out  (noc2_data_out),
    .noc2_ready_out (noc2_ready_out),
    .busy           (busy),
    .grant          (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] hdr(input logic [7:0] len, input logic [15:0] tag);
    logic [63:0] h;
    h = '0;
    h[29:22] = len;
    h[63:48] = tag;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] p;
    int o;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    noc2_ready_out = 1'b0;
    step(); step();
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_valid", noc2_valid_out, 0);
    chk("rst_data", noc2_data_out, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_cnt", dut.cnt_q, 0);

    // two single-flit headers contending
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = hdr(0, 16'hA000);
    req1_valid = 1'b1; req1_data = hdr(0, 16'hB000);
    noc2_ready_out = 1'b1;
    #2;
    chk("t032_grant1", grant, 2'b01);
    chk("t032_data1", noc2_data_out, hdr(0, 16'hA000));
    chk("t032_rdy0", req0_ready, 1);
    chk("t032_rdy1_lo", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    #2;
    chk("t032_grant2", grant, 2'b10);
    chk("t032_data2", noc2_data_out, hdr(0, 16'hB000));
    chk("t032_rdy1", req1_ready, 1);
    chk("t032_busy", busy, 0);
    step();
    req1_valid = 1'b0;

    // four-flit req0 packet with req1 waiting
    req0_valid = 1'b1; req0_data = hdr(3, 16'hC000);
    req1_valid = 1'b1; req1_data = hdr(0, 16'hD000);
    #2;
    chk("t033_hdr_grant", grant, 2'b01);
    chk("t033_hdr_busy", busy, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      req0_data = 64'h0000_0000_CCCC_0000 + 64'(i);
      #2;
      chk("t033_busy", busy, 1);
      chk("t033_grant", grant, 2'b01);
      chk("t033_data", noc2_data_out, 64'h0000_0000_CCCC_0000 + 64'(i));
      chk("t033_rdy1_lo", req1_ready, 0);
    end
    step();
    req0_valid = 1'b0;
    #2;
    chk("t033_b2b_busy", busy, 0);
    chk("t033_b2b_grant", grant, 2'b10);
    chk("t033_b2b_data", noc2_data_out, hdr(0, 16'hD000));
    step();
    req1_valid = 1'b0;

    // back-pressure and an owner gap mid-packet
    req0_valid = 1'b1; req0_data = hdr(3, 16'hF000);
    step();
    req0_data = 64'h1111;
    step();
    chk("t034_cnt2", dut.cnt_q, 2);
    req0_data = 64'h2222;
    req1_valid = 1'b1; req1_data = hdr(0, 16'h6000);
    noc2_ready_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("t034_hold_cnt", dut.cnt_q, 2);
      chk("t034_hold_data", noc2_data_out, 64'h2222);
      chk("t034_hold_grant", grant, 2'b01);
      chk("t034_hold_rdy0", req0_ready, 0);
      step();
    end
    noc2_ready_out = 1'b1;
    req0_valid = 1'b0;
    #2;
    chk("t034_gap_valid", noc2_valid_out, 0);
    chk("t034_gap_rdy1", req1_ready, 0);
    chk("t034_gap_grant", grant, 2'b01);
    step();
    chk("t034_gap_cnt", dut.cnt_q, 2);
    req0_valid = 1'b1;
    #2;
    chk("t034_resume_rdy0", req0_ready, 1);
    step();
    chk("t034_cnt1", dut.cnt_q, 1);
    req0_data = 64'h3333;
    step();
    req0_valid = 1'b0;
    #2;
    chk("t034_done_busy", busy, 0);
    chk("t034_done_grant", grant, 2'b10);
    step();
    req1_valid = 1'b0;

    // continuous two-flit packets from both requesters, fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = hdr(1, 16'h0A00);
    req1_valid = 1'b1; req1_data = hdr(1, 16'h1A00);
    for (int k = 0; k < 4; k++) begin
`ifdef NOC2_ARB_RR_EN
      o = k % 2;
`else
      o = 0;
`endif
      p = 64'h0000_0000_5A5A_0000 + 64'(k);
      #2;
      chk("t035_hdr_grant", grant, (o == 1) ? 2'b10 : 2'b01);
      chk("t035_hdr_busy", busy, 0);
      step();
      if (o == 0) req0_data = p; else req1_data = p;
      #2;
      chk("t035_pay_grant", grant, (o == 1) ? 2'b10 : 2'b01);
      chk("t035_pay_data", noc2_data_out, p);
      chk("t035_pay_busy", busy, 1);
      step();
      req0_data = hdr(1, 16'h0A00);
      req1_data = hdr(1, 16'h1A00);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // reset abandons a req1 packet with five flits remaining
    req1_valid = 1'b1; req1_data = hdr(5, 16'h7000);
    #2;
    chk("t036_hdr_grant", grant, 2'b10);
    step();
    req1_data = 64'h7777;
    #2;
    chk("t036_cnt5", dut.cnt_q, 5);
    chk("t036_busy", busy, 1);
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = hdr(0, 16'h8000);
    #2;
    chk("t036_rstcyc_grant", grant, 2'b10);
    chk("t036_rstcyc_data", noc2_data_out, 64'h7777);
    step();
    rst_n = 1'b1;
    #2;
    chk("t036_post_busy", busy, 0);
    chk("t036_post_cnt", dut.cnt_q, 0);
    chk("t036_post_grant", grant, 2'b01);
    chk("t036_post_data", noc2_data_out, hdr(0, 16'h8000));
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/noc2_out_arb.md
NOC2_OUT_ARB -- requirements
Module: noc2_out_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: NoC flit width.
REQ-002 SHALL have parameter LEN_MSB, default 29: MSB of the header payload-length field.
REQ-003 SHALL have parameter LEN_LSB, default 22: LSB of the header payload-length field (8 bits by default).
REQ-004 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: synchronous, active-low reset.
REQ-006 SHALL have port req0_valid  input  1: requester 0 offers a flit.
REQ-007 SHALL have port req0_data  input  DATA_WIDTH: requester 0 flit.
REQ-008 SHALL have port req0_ready  output  1: requester 0 flit accepted this cycle.
REQ-009 SHALL have ports req1_valid, req1_data and req1_ready with widths and meanings identical to requester 0.
REQ-010 SHALL have port noc2_valid_out  output  1: flit valid toward the NoC2 channel.
REQ-011 SHALL have port noc2_data_out  output  DATA_WIDTH: flit toward NoC2.
REQ-012 SHALL have port noc2_ready_out  input  1: NoC2 accepts the flit.
REQ-013 SHALL have port busy  output  1: a packet is mid-transfer (state SEND).
REQ-014 SHALL have port grant  output  2: one-hot owner of the output; 2'b00 when nothing is selected.

Function
REQ-015 SHALL share one NoC2 output between two requesters, with packet-atomic transfer: no flits of another packet are interleaved.
REQ-016 SHALL define a transfer as the cycle in which noc2_valid_out and noc2_ready_out are both 1.
REQ-017 SHALL implement FSM states IDLE and SEND, plus a remaining-flit counter of width LEN_MSB-LEN_LSB+1.
REQ-018 In IDLE, SHALL select a requester among those with valid high, per the arbitration policy (REQ-030/031).
REQ-019 In SEND, SHALL select the locked owner only.
REQ-020 SHALL be combinational from input to output, with zero-cycle latency:
- noc2_data_out and noc2_valid_out equal the selected requester's data and valid;
- the selected requester's ready equals noc2_ready_out;
- the unselected requester's ready is 0.
REQ-021 When no requester is selected: noc2_valid_out=0, noc2_data_out=0, both readies 0.
REQ-022 On a header transfer in IDLE with length field L:
- L==0: stay IDLE (single-flit packet);
- L>0: go to SEND, counter<=L, lock owner.
REQ-023 In SEND, each transfer SHALL decrement the counter; a transfer at counter==1 SHALL return the FSM to IDLE.
REQ-024 Requesters SHALL hold valid and data stable until accepted; the arbiter's selection in IDLE SHALL change only when its inputs change or a header is accepted.
REQ-025 In SEND, a gap in owner valid SHALL hold state; the other requester's valid SHALL be ignored.
REQ-026 Back-to-back packets SHALL be supported: the header of the next packet may transfer in the cycle after the last flit.
REQ-027 busy SHALL equal (state==SEND); grant SHALL reflect the current combinational selection.

Reset
REQ-028 While rst_n==0 at a rising clk edge, the next state SHALL be:
- state=IDLE;
- counter=0;
- last-grant pointer=requester 1, so requester 0 wins first.
REQ-029 Reset asserted mid-packet SHALL abandon the packet with no flush. In the reset cycle the outputs SHALL follow REQ-020/021 from current state; from the following cycle, busy=0.

Configuration
REQ-030 With NOC2_ARB_RR_EN defined, arbitration in IDLE SHALL be round-robin:
- when both requesters are valid, the one not named by the last-grant pointer wins;
- the pointer updates to the winner on each header transfer.
REQ-031 Without NOC2_ARB_RR_EN, requester 0 SHALL have fixed priority and the pointer logic SHALL be absent.

Verification
REQ-032 Reset, then both valid, each a 1-flit header (L=0), ready=1: req0 transfers in cycle 1, req1 in cycle 2; grant=01 then 10.
REQ-033 req0 packet L=3 with req1 valid throughout, ready=1: four req0 flits consecutively with busy=1 for flits 2-4 and req1_ready=0; then req1 header.
REQ-034 noc2_ready_out=0 for 5 cycles mid-packet (counter=2): counter stays 2, data stable, owner unchanged; completes after ready returns.
REQ-035 NOC2_ARB_RR_EN defined, both requesters continuously sending L=1 packets: ownership alternates per packet (0,0,1,1,0,0...). Undefined: req0 owns all packets.
REQ-036 rst_n=0 while in SEND with counter=5: next cycle state=IDLE, busy=0, and the next granted header is req0's.
